// File: rtl/video_frame_monitor.sv
// Passive monitor for a parallel video bus: measures active width/height per frame, counts
// frames, accumulates a pixel checksum and keeps sticky timing-error flags.
module video_frame_monitor #(
    parameter int DATA_WIDTH    = 8,
    parameter int PIXEL_PER_CLK = 1,
    parameter int XCNT_WIDTH    = 12,
    parameter int YCNT_WIDTH    = 12,
    parameter int FRCNT_WIDTH   = 16
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [DATA_WIDTH*PIXEL_PER_CLK-1:0]   di_i,
    input  logic                                  de_i,
    input  logic                                  hs_i,
    input  logic                                  vs_i,
    input  logic                                  clr_i,
    output logic                                  fr_done_o,
    output logic [XCNT_WIDTH-1:0]                 fr_width_o,
    output logic [YCNT_WIDTH-1:0]                 fr_height_o,
    output logic [31:0]                           fr_sum_o,
    output logic [FRCNT_WIDTH-1:0]                frcnt_o,
    output logic [3:0]                            err_o
);
    localparam int DW = DATA_WIDTH * PIXEL_PER_CLK;
    localparam logic [XCNT_WIDTH:0] PPC_X = (XCNT_WIDTH+1)'(PIXEL_PER_CLK);

    typedef enum logic [1:0] {S_WAIT_VS = 2'd0, S_VBLANK = 2'd1, S_ACTIVE = 2'd2} state_t;

    state_t                  state_q, state_d;
    logic [DW-1:0]           r_di_q;
    logic                    r_de_q, r_hs_q, r_vs_q, r_clr_q, de_p_q, vs_p_q;
    logic [XCNT_WIDTH-1:0]   xcnt_q, xcnt_d, ref_q, ref_d;
    logic [YCNT_WIDTH-1:0]   ycnt_q, ycnt_d;
    logic [31:0]             sum_q, sum_d, lane_sum;
    logic [3:0]              err_set, err_q, err_d;
    logic                    pub_q, pub_d, have_prev_q, height_err;
    logic [XCNT_WIDTH-1:0]   pub_width_q, pub_width_d, fr_width_q;
    logic [YCNT_WIDTH-1:0]   pub_height_q, pub_height_d, fr_height_q;
    logic [31:0]             pub_sum_q, pub_sum_d, fr_sum_q;
    logic                    fr_done_q;
    logic [FRCNT_WIDTH-1:0]  frcnt_q, frcnt_d;
    logic [XCNT_WIDTH:0]     x_ext;
    logic [YCNT_WIDTH:0]     y_ext;
    logic [XCNT_WIDTH-1:0]   x_sat;
    logic [YCNT_WIDTH-1:0]   y_sat;
    logic                    vs_rise, vs_fall, de_fall, line_end;

    always_comb begin
        lane_sum = '0;
        for (int k = 0; k < PIXEL_PER_CLK; k++)
            lane_sum = lane_sum + 32'(r_di_q[k*DATA_WIDTH +: DATA_WIDTH]);
    end

    assign vs_rise  = r_vs_q & ~vs_p_q;
    assign vs_fall  = ~r_vs_q & vs_p_q;
    assign de_fall  = ~r_de_q & de_p_q;
    assign x_ext    = {1'b0, xcnt_q} + (r_de_q ? PPC_X : '0);
    assign x_sat    = x_ext[XCNT_WIDTH] ? '1 : x_ext[XCNT_WIDTH-1:0];
    assign y_ext    = {1'b0, ycnt_q} + {{YCNT_WIDTH{1'b0}}, 1'b1};
    assign y_sat    = y_ext[YCNT_WIDTH] ? '1 : y_ext[YCNT_WIDTH-1:0];
    // A vs rise while de is still high closes the partial line as an ordinary line end.
    assign line_end = (x_sat != '0) && (de_fall || (vs_rise && r_de_q));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_WAIT_VS;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_WAIT_VS: if (vs_rise) state_d = S_VBLANK;
            S_VBLANK:  if (vs_fall) state_d = S_ACTIVE;
            S_ACTIVE:  if (vs_rise) state_d = S_VBLANK;
            default:   state_d = S_WAIT_VS;
        endcase
    end

    always_comb begin
        xcnt_d       = xcnt_q;
        ycnt_d       = ycnt_q;
        ref_d        = ref_q;
        sum_d        = sum_q;
        err_set      = '0;
        pub_d        = 1'b0;
        pub_width_d  = pub_width_q;
        pub_height_d = pub_height_q;
        pub_sum_d    = pub_sum_q;
        if (state_q != S_WAIT_VS && r_de_q && r_hs_q) err_set[2] = 1'b1;
        case (state_q)
            S_VBLANK: begin
                if (vs_fall) begin
                    xcnt_d = '0;
                    ycnt_d = '0;
                    ref_d  = '0;
                    sum_d  = '0;
                end
            end
            S_ACTIVE: begin
                xcnt_d = x_sat;
                if (r_de_q) begin
                    sum_d = sum_q + lane_sum;
                    if (x_ext[XCNT_WIDTH]) err_set[3] = 1'b1;
                end
                if (line_end) begin
                    ycnt_d = y_sat;
                    if (y_ext[YCNT_WIDTH]) err_set[3] = 1'b1;
                    if (ycnt_q == '0)        ref_d = x_sat;
                    else if (x_sat != ref_q) err_set[0] = 1'b1;
                    xcnt_d = '0;
                end
                if (vs_rise) begin
                    pub_d        = 1'b1;
                    pub_width_d  = ref_d;
                    pub_height_d = ycnt_d;
                    pub_sum_d    = sum_d;
                end
            end
            default: ;
        endcase
    end

    assign height_err = pub_q && have_prev_q && (pub_height_q != fr_height_q);

    always_comb begin
        err_d   = err_q | err_set | {2'b00, height_err, 1'b0};
        frcnt_d = frcnt_q + (pub_q ? FRCNT_WIDTH'(1) : '0);
        if (r_clr_q) begin
            err_d   = '0;
            frcnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_di_q <= '0; r_de_q <= 1'b0; r_hs_q <= 1'b0; r_vs_q <= 1'b0; r_clr_q <= 1'b0;
            de_p_q <= 1'b0; vs_p_q <= 1'b0;
            xcnt_q <= '0; ycnt_q <= '0; ref_q <= '0; sum_q <= '0;
            pub_q <= 1'b0; pub_width_q <= '0; pub_height_q <= '0; pub_sum_q <= '0;
            fr_done_q <= 1'b0; fr_width_q <= '0; fr_height_q <= '0; fr_sum_q <= '0;
            frcnt_q <= '0; err_q <= '0; have_prev_q <= 1'b0;
        end else begin
            r_di_q <= di_i; r_de_q <= de_i; r_hs_q <= hs_i; r_vs_q <= vs_i; r_clr_q <= clr_i;
            de_p_q <= r_de_q; vs_p_q <= r_vs_q;
            xcnt_q <= xcnt_d; ycnt_q <= ycnt_d; ref_q <= ref_d; sum_q <= sum_d;
            pub_q <= pub_d; pub_width_q <= pub_width_d;
            pub_height_q <= pub_height_d; pub_sum_q <= pub_sum_d;
            fr_done_q <= pub_q;
            if (pub_q) begin
                fr_width_q  <= pub_width_q;
                fr_height_q <= pub_height_q;
                fr_sum_q    <= pub_sum_q;
                have_prev_q <= 1'b1;
            end
            frcnt_q <= frcnt_d;
            err_q   <= err_d;
        end
    end

    assign fr_done_o   = fr_done_q;
    assign fr_width_o  = fr_width_q;
    assign fr_height_o = fr_height_q;
    assign fr_sum_o    = fr_sum_q;
    assign frcnt_o     = frcnt_q;
    assign err_o       = err_q;
endmodule
